// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU instruction and data channels: one single-port word array,
// one transaction in flight, configurable request-ack and response latency.
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int REQ_DELAY  = 1,
    parameter int RESP_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack
);
    typedef enum logic [2:0] {IDLE, REQ_WAIT, ACK, RESP_WAIT, RESP} state_t;
    typedef enum logic [1:0] {SEL_INST, SEL_READ, SEL_WRITE} sel_t;

    localparam logic [3:0] REQ_LAST  = 4'(REQ_DELAY - 1);
    localparam logic [3:0] RESP_LAST = 4'(RESP_DELAY - 1);

    state_t state_q, state_d;
    sel_t   sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] inst_q, inst_d, rdata_q, rdata_d;
    logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    logic                  sel_valid, resp_ack, mem_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           mem_rd;

    always_comb begin
        sel_valid = 1'b0;
        resp_ack  = 1'b0;
        case (sel_q)
            SEL_INST:  begin sel_valid = Inst_Req_Valid; resp_ack = Inst_Ack; end
            SEL_READ:  begin sel_valid = MemRead;        resp_ack = Read_data_Ack; end
            SEL_WRITE: sel_valid = MemWrite;
            default:   sel_valid = 1'b0;
        endcase
    end

    // Upper address bits beyond the array size are ignored, so addresses alias.
    assign idx    = (sel_q == SEL_INST) ? PC[ADDR_WIDTH+1:2] : Address[ADDR_WIDTH+1:2];
    assign mem_rd = mem_q[idx];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (MemWrite || MemRead || Inst_Req_Valid) begin
                    if (MemWrite)     sel_d = SEL_WRITE;
                    else if (MemRead) sel_d = SEL_READ;
                    else              sel_d = SEL_INST;
                    state_d = (REQ_DELAY == 0) ? ACK : REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (!sel_valid)            state_d = IDLE;
                else if (cnt_q == REQ_LAST) state_d = ACK;
                else                        cnt_d = cnt_q + 4'd1;
            end
            ACK: begin
                cnt_d = '0;
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (sel_q == SEL_WRITE) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (sel_q == SEL_INST) inst_d  = mem_rd;
                    else                   rdata_d = mem_rd;
                    state_d = (RESP_DELAY == 0) ? RESP : RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                if (cnt_q == RESP_LAST) state_d = RESP;
                else                    cnt_d = cnt_q + 4'd1;
            end
            RESP: begin
                if (resp_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_INST;
            cnt_q   <= '0;
            inst_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            rdata_q <= rdata_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (Write_strb[i]) mem_q[idx][8*i +: 8] <= Write_data[8*i +: 8];
        end
    end

    assign Inst_Req_Ack    = (state_q == ACK) && (sel_q == SEL_INST) && Inst_Req_Valid;
    assign Mem_Req_Ack     = (state_q == ACK) && (sel_q != SEL_INST) && sel_valid;
    assign Inst_Valid      = (state_q == RESP) && (sel_q == SEL_INST);
    assign Read_data_Valid = (state_q == RESP) && (sel_q == SEL_READ);
    assign Instruction     = inst_q;
    assign Read_data       = rdata_q;
endmodule
